// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with scoreboard pending bits, optional zero reg/bypass and clear sweep
module reg_file_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 0
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  input  logic                  RESERVE,
  input  logic [ADDR_WIDTH-1:0] RESADDRESS,
  output logic                  OUT1_PEND,
  output logic                  OUT2_PEND,
  input  logic                  CLEAR,
  output logic                  CLR_BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  wr_acc;
  logic                  rs_acc;

  assign CLR_BUSY = (state == ST_SWEEP);

  // Register 0 is never a target when it is hardwired to zero.
  assign wr_acc = WRITE && !CLR_BUSY && !((ZERO_REG != 0) && (INADDRESS == '0));
  assign rs_acc = RESERVE && !CLR_BUSY && !((ZERO_REG != 0) && (RESADDRESS == '0));

  // State update: reset, clear sweep, or normal writeback/reservation.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend  <= '0;
      state <= ST_IDLE;
      idx   <= '0;
    end else if (state == ST_SWEEP) begin
      regs[idx] <= '0;
      pend[idx] <= 1'b0;
      idx       <= idx + 1'b1;
      if (idx == LAST_IDX) begin
        state <= ST_IDLE;
      end
    end else begin
      if (wr_acc) begin
        regs[INADDRESS] <= IN;
        pend[INADDRESS] <= 1'b0;
      end
      // Later assignment wins: a new producer re-marks the register pending.
      if (rs_acc) begin
        pend[RESADDRESS] <= 1'b1;
      end
      if (CLEAR) begin
        state <= ST_SWEEP;
        idx   <= '0;
      end
    end
  end

  // Read port 1: array lookup, then bypass, then zero-register override.
  always_comb begin
    OUT1      = regs[OUT1ADDRESS];
    OUT1_PEND = pend[OUT1ADDRESS];
    if ((BYPASS != 0) && wr_acc && (OUT1ADDRESS == INADDRESS)) begin
      OUT1 = IN;
    end
    if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
      OUT1      = '0;
      OUT1_PEND = 1'b0;
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    OUT2      = regs[OUT2ADDRESS];
    OUT2_PEND = pend[OUT2ADDRESS];
    if ((BYPASS != 0) && wr_acc && (OUT2ADDRESS == INADDRESS)) begin
      OUT2 = IN;
    end
    if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
      OUT2      = '0;
      OUT2_PEND = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb (default and zero-reg/bypass builds)
module tb_reg_file_sb;

  logic       CLK;
  logic       RESETN;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic       RESERVE;
  logic [2:0] RESADDRESS;
  logic       CLEAR;

  logic [7:0] a_out1, a_out2, b_out1, b_out2;
  logic       a_p1, a_p2, b_p1, b_p2, a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  reg_file_sb dut_a (
    .CLK(CLK), .RESETN(RESETN), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(a_out1), .OUT2(a_out2),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .OUT1_PEND(a_p1), .OUT2_PEND(a_p2),
    .CLEAR(CLEAR), .CLR_BUSY(a_busy)
  );

  reg_file_sb #(.ZERO_REG(1), .BYPASS(1)) dut_b (
    .CLK(CLK), .RESETN(RESETN), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(b_out1), .OUT2(b_out2),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .OUT1_PEND(b_p1), .OUT2_PEND(b_p2),
    .CLEAR(CLEAR), .CLR_BUSY(b_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Behavioural model: unit 0 = default build, unit 1 = zero-reg + bypass build.
  logic [7:0] mreg  [2][8];
  bit         mpend [2][8];
  bit         mbusy [2];
  int         mleft [2];
  bit         m_wa, m_ra;

  function automatic logic [7:0] mread(input int u, input logic [2:0] a);
    if (u == 1 && a == 3'd0) return 8'h00;
    if (u == 1 && WRITE && !mbusy[u] && INADDRESS == a) return IN;
    return mreg[u][a];
  endfunction

  function automatic logic mpread(input int u, input logic [2:0] a);
    if (u == 1 && a == 3'd0) return 1'b0;
    return mpend[u][a];
  endfunction

  always @(posedge CLK or negedge RESETN) begin
    for (int u = 0; u < 2; u++) begin
      if (!RESETN) begin
        for (int r = 0; r < 8; r++) begin
          mreg[u][r]  = 8'h00;
          mpend[u][r] = 1'b0;
        end
        mbusy[u] = 1'b0;
        mleft[u] = 0;
      end else if (mbusy[u]) begin
        // Sweep clears one register per edge in ascending order.
        mreg[u][8 - mleft[u]]  = 8'h00;
        mpend[u][8 - mleft[u]] = 1'b0;
        mleft[u] = mleft[u] - 1;
        if (mleft[u] == 0) mbusy[u] = 1'b0;
      end else begin
        m_wa = WRITE && !(u == 1 && INADDRESS == 3'd0);
        m_ra = RESERVE && !(u == 1 && RESADDRESS == 3'd0);
        if (m_wa) begin
          mreg[u][INADDRESS]  = IN;
          mpend[u][INADDRESS] = 1'b0;
        end
        if (m_ra) mpend[u][RESADDRESS] = 1'b1;
        if (CLEAR) begin
          mbusy[u] = 1'b1;
          mleft[u] = 8;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("cyc_a_out1", a_out1, mread(0, OUT1ADDRESS));
    chk("cyc_a_out2", a_out2, mread(0, OUT2ADDRESS));
    chk("cyc_a_p1", a_p1, mpread(0, OUT1ADDRESS));
    chk("cyc_a_p2", a_p2, mpread(0, OUT2ADDRESS));
    chk("cyc_a_busy", a_busy, mbusy[0]);
    chk("cyc_b_out1", b_out1, mread(1, OUT1ADDRESS));
    chk("cyc_b_out2", b_out2, mread(1, OUT2ADDRESS));
    chk("cyc_b_p1", b_p1, mpread(1, OUT1ADDRESS));
    chk("cyc_b_p2", b_p2, mpread(1, OUT2ADDRESS));
    chk("cyc_b_busy", b_busy, mbusy[1]);
  end

  initial begin
    int n;
    IN = 8'h00; INADDRESS = 3'd0; WRITE = 1'b0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    RESERVE = 1'b0; RESADDRESS = 3'd0; CLEAR = 1'b0; RESETN = 1'b1;

    // Asynchronous reset before any clock edge.
    #2 RESETN = 1'b0;
    #1;
    chk("rst_a_out1", a_out1, 8'h00);
    chk("rst_a_out2", a_out2, 8'h00);
    chk("rst_a_pend", {a_p1, a_p2}, 2'b00);
    chk("rst_busy", {a_busy, b_busy}, 2'b00);
    tick();
    tick();
    RESETN = 1'b1;

    // Write reg 2 = 0x1F; bypass visible same cycle on unit b only.
    WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h1F; OUT1ADDRESS = 3'd2;
    #1;
    chk("byp_b_out1", b_out1, 8'h1F);
    chk("nobyp_a_out1", a_out1, 8'h00);
    tick();
    WRITE = 1'b0;
    #1;
    chk("wr_a_out1", a_out1, 8'h1F);
    chk("wr_b_out1", b_out1, 8'h1F);

    // Reserve reg 4.
    RESERVE = 1'b1; RESADDRESS = 3'd4; OUT2ADDRESS = 3'd4;
    tick();
    RESERVE = 1'b0;
    #1;
    chk("res_a_p2", a_p2, 1'b1);
    chk("res_b_p2", b_p2, 1'b1);

    // Write reg 4 = 0x55 clears pending.
    WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h55;
    tick();
    WRITE = 1'b0;
    #1;
    chk("wb_a_out2", a_out2, 8'h55);
    chk("wb_a_p2", a_p2, 1'b0);

    // Same-edge write + reserve on reg 4: new data, pending set.
    WRITE = 1'b1; RESERVE = 1'b1; INADDRESS = 3'd4; RESADDRESS = 3'd4; IN = 8'h66;
    tick();
    WRITE = 1'b0; RESERVE = 1'b0;
    #1;
    chk("wrres_a_out2", a_out2, 8'h66);
    chk("wrres_a_p2", a_p2, 1'b1);
    chk("wrres_b_p2", b_p2, 1'b1);

    // Write + reserve reg 0: ignored on zero-reg build.
    WRITE = 1'b1; RESERVE = 1'b1; INADDRESS = 3'd0; RESADDRESS = 3'd0; IN = 8'hFF;
    OUT1ADDRESS = 3'd0;
    #1;
    chk("z_b_nobyp", b_out1, 8'h00);
    tick();
    WRITE = 1'b0; RESERVE = 1'b0;
    #1;
    chk("z_a_out1", a_out1, 8'hFF);
    chk("z_a_p1", a_p1, 1'b1);
    chk("z_b_out1", b_out1, 8'h00);
    chk("z_b_p1", b_p1, 1'b0);

    // Fill all registers with 0xAA.
    for (int i = 0; i < 8; i++) begin
      WRITE = 1'b1; INADDRESS = 3'(i); IN = 8'hAA;
      tick();
    end
    WRITE = 1'b0;

    // Clear sweep: reg k zero after the (k+1)th sweep edge; writes dropped, CLEAR ignored.
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      OUT1ADDRESS = 3'(j - 1);
      if (j == 3) begin
        WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'h11; RESERVE = 1'b1; RESADDRESS = 3'd1;
      end
      if (j == 5) CLEAR = 1'b1;
      #1;
      chk("sw_busy", a_busy, 1'b1);
      chk("sw_pre", a_out1, 8'hAA);
      tick();
      WRITE = 1'b0; RESERVE = 1'b0; CLEAR = 1'b0;
      #1;
      chk("sw_post", a_out1, 8'h00);
    end
    chk("sw_done_a", a_busy, 1'b0);
    chk("sw_done_b", b_busy, 1'b0);
    OUT1ADDRESS = 3'd1;
    #1;
    chk("sw_drop_out", a_out1, 8'h00);
    chk("sw_drop_pend", a_p1, 1'b0);
    tick();
    chk("sw_no_restart", a_busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = 3'(i); OUT2ADDRESS = 3'(7 - i);
      #1;
      chk("sw_zero_a1", a_out1, 8'h00);
      chk("sw_zero_a2", a_out2, 8'h00);
    end

    // Reset aborts a sweep at cycle 3; a fresh sweep is then a full 8 cycles.
    WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'h77;
    tick();
    WRITE = 1'b0; OUT1ADDRESS = 3'd5;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    tick();
    tick();
    tick();
    #2;
    chk("ab_pre_out", a_out1, 8'h77);
    chk("ab_pre_busy", a_busy, 1'b1);
    RESETN = 1'b0;
    #1;
    chk("ab_busy", {a_busy, b_busy}, 2'b00);
    chk("ab_out", a_out1, 8'h00);
    tick();
    RESETN = 1'b1;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    n = 0;
    while (a_busy && n < 20) begin
      n++;
      tick();
    end
    chk("sweep2_len", n, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised next-generation CPU register file: configurable data width and depth, two combinational read ports, one synchronous write port.
- Adds an optional hardwired-zero register 0, optional write-to-read bypass, and a per-register pending (scoreboard) bit for pipelined hazard detection.
- Adds a multi-cycle synchronous clear sweep.
- Sits between the decode stage (read addresses, reservations) and the writeback stage (write port).

Parameters:
- DATA_WIDTH, 8, bits per register
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH registers
- ZERO_REG, 0, 1 = register 0 always reads 0; writes and reservations to it are ignored
- BYPASS, 0, 1 = an accepted write to the address being read appears on that read port in the same cycle

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESETN  in  1  asynchronous active-low reset
- IN  in  DATA_WIDTH  write data
- INADDRESS  in  ADDR_WIDTH  write address
- WRITE  in  1  write enable
- OUT1ADDRESS  in  ADDR_WIDTH  read port 1 address
- OUT2ADDRESS  in  ADDR_WIDTH  read port 2 address
- OUT1  out  DATA_WIDTH  read port 1 data
- OUT2  out  DATA_WIDTH  read port 2 data
- RESERVE  in  1  mark a register pending (result in flight)
- RESADDRESS  in  ADDR_WIDTH  register to reserve
- OUT1_PEND  out  1  pending bit of OUT1ADDRESS
- OUT2_PEND  out  1  pending bit of OUT2ADDRESS
- CLEAR  in  1  start clear sweep
- CLR_BUSY  out  1  sweep in progress

Behaviour:
- Reset (RESETN=0, asynchronous):
  - all registers 0, all pending bits 0, FSM to IDLE, sweep index 0, CLR_BUSY=0.
  - OUT1/OUT2 therefore read 0 and OUTx_PEND read 0 immediately, with no clock edge needed.
- Reads are combinational, with zero cycles of latency:
  - OUTx = reg[OUTxADDRESS] and OUTx_PEND = pend[OUTxADDRESS].
  - With ZERO_REG=1, address 0 always gives OUTx=0 and OUTx_PEND=0.
- Write acceptance:
  - A write is accepted when WRITE=1, CLR_BUSY=0, and not (ZERO_REG=1 and INADDRESS=0).
  - On the rising edge, reg[INADDRESS] <= IN and pend[INADDRESS] <= 0.
  - The new value is visible on the read ports the cycle after the edge.
- Bypass (BYPASS=1): while a write is accepted and OUTxADDRESS==INADDRESS, OUTx=IN combinationally. OUTx_PEND is unaffected by bypass.
- Reservation acceptance:
  - A reservation is accepted when RESERVE=1, CLR_BUSY=0, and not (ZERO_REG=1 and RESADDRESS=0).
  - On the rising edge, pend[RESADDRESS] <= 1.
- Same edge, same address, write and reserve: data is written and pending ends at 1 (the new producer wins).
- Same edge, different addresses: both take effect.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on a rising edge with CLEAR=1. The index is 0 on entry and CLR_BUSY=1 from the following cycle.
  - Each edge in SWEEP: reg[idx] <= 0, pend[idx] <= 0, idx <= idx+1.
  - At the edge that clears idx=DEPTH-1, the FSM returns to IDLE and idx returns to 0.
  - CLR_BUSY is high for exactly DEPTH cycles.
- Rules during SWEEP:
  - CLEAR is ignored.
  - WRITE and RESERVE are dropped; they are not queued.
  - Reads remain live and return mixed old and zeroed contents.
- Upstream must stall writeback while CLR_BUSY=1.
- RESETN asserted mid-sweep aborts the sweep immediately; full reset state applies.
- Index arithmetic is ADDR_WIDTH bits wide and wraps naturally at DEPTH-1. No out-of-range addresses exist.
- No X on outputs after reset. Reads of never-written registers return 0.

Test Plan:
- Reset: drive RESETN=0 mid-cycle with no clock edge -> OUT1=OUT2=0, both PEND=0, CLR_BUSY=0 immediately.
- Write then read: WRITE=1, INADDRESS=2, IN=0x1F, edge; OUT1ADDRESS=2 -> OUT1=0x1F one cycle after the edge. With BYPASS=1, OUT1=0x1F in the same cycle as WRITE.
- Scoreboard:
  - RESERVE reg 4, edge -> OUT2_PEND=1 for OUT2ADDRESS=4.
  - WRITE reg 4 = 0x55, edge -> OUT2=0x55, OUT2_PEND=0.
  - Same-edge RESERVE+WRITE reg 4 -> OUT2=new data, OUT2_PEND=1.
- ZERO_REG=1: WRITE reg 0 = 0xFF and RESERVE reg 0 -> OUT1 for address 0 reads 0x00, PEND=0.
- Clear sweep (defaults, DEPTH=8):
  - Fill all registers with 0xAA, pulse CLEAR -> CLR_BUSY high exactly 8 cycles, with reg k reading 0 after the (k+1)th sweep edge.
  - A WRITE during the sweep is dropped.
  - All registers read 0 afterwards.
- Reset mid-sweep: assert RESETN=0 at sweep cycle 3 -> CLR_BUSY=0 and all registers 0 at once. After release, CLEAR starts a fresh 8-cycle sweep.
